// File: rtl/fetch_pkg.sv
// Purpose : shared types and constants for the instruction-fetch stage.
// Latency : n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   fetch_state_t     - fetch FSM state encoding
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   PC_STEP_PAIR/ONE  - PC advance for a two-entry / one-entry write
//   line_addr()       - doubleword-aligned cache address for a PC
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ       = 2'd0,  // ready to issue a cache request
    WAIT_DATA = 2'd1,  // request accepted, response will be written to the FIFO
    DISCARD   = 2'd2,  // request accepted, response must be dropped
    ERR_HOLD  = 2'd3   // misaligned PC reported, parked until a redirect
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP_PAIR     = 32'd8;
  localparam logic [31:0] PC_STEP_ONE      = 32'd4;

  // The cache always returns a full 64-bit doubleword, so requests drop pc[2:0].
  function automatic logic [31:0] line_addr(input logic [31:0] pc);
    return {pc[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_pack.sv
// Purpose : maps a cache response (or an address error) onto the two FIFO write entries.
// Latency : combinational, same cycle as data_wr / err_wr.
// Backpressure: none; the caller only enables a write when the FIFO has >= 2 free entries.
//
// Ports:
//   pc        - PC of the first instruction being written
//   rdata     - 64-bit doubleword, [31:0] at line address, [63:32] at line address + 4
//   data_wr   - write the response (pc must be word aligned)
//   err_wr    - write a single address-error entry for pc
//   instr1_*/instr2_* - FIFO write-port fields, zero when the entry is not written
module fetch_pack
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [63:0] rdata,
  input  logic        data_wr,
  input  logic        err_wr,
  output logic        instr1_wen,
  output logic        instr2_wen,
  output logic [31:0] instr1_addr,
  output logic [31:0] instr2_addr,
  output logic [31:0] instr1_data,
  output logic [31:0] instr2_data,
  output logic        instr1_addr_err,
  output logic        instr2_addr_err
);

  logic pair;  // pc sits in the low word, so both words of the doubleword are useful

  always_comb begin
    pair            = data_wr && !pc[2];

    instr1_wen      = 1'b0;
    instr1_addr     = '0;
    instr1_data     = '0;
    instr1_addr_err = 1'b0;
    instr2_wen      = 1'b0;
    instr2_addr     = '0;
    instr2_data     = '0;
    instr2_addr_err = 1'b0;

    if (err_wr) begin
      // The faulting PC travels down the pipe with an empty instruction word.
      instr1_wen      = 1'b1;
      instr1_addr     = pc;
      instr1_addr_err = 1'b1;
    end else if (data_wr) begin
      // The upper word is always written; a lone instruction goes into entry 2.
      instr2_wen  = 1'b1;
      instr2_data = rdata[63:32];
      instr2_addr = pair ? pc + PC_STEP_ONE : pc;
      if (pair) begin
        instr1_wen  = 1'b1;
        instr1_addr = pc;
        instr1_data = rdata[31:0];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Purpose : instruction-fetch stage: PC generation, I-cache handshake, FIFO write, redirects.
// Latency : FIFO write in the same cycle as inst_data_ok; next request earliest the cycle after.
// Backpressure: no request unless the FIFO has >= 2 free entries (fifo_isfull/fifo_willfull low).
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset (all outputs 0 while high)
//   redirect_*            - one-cycle branch/exception redirect, overrides everything that cycle
//   fifo_isfull/willfull  - FIFO free-space status
//   inst_req/addr/addr_ok - cache request channel (one access in flight at most)
//   inst_data_ok/rdata    - cache response channel
//   fifo_instr{1,2}_*     - FIFO write port
//   perf_fetch_cnt        - instructions written to the FIFO
//   perf_flush_cnt        - cache responses discarded
//
// Optional: define FETCH_PERF_CNT_EN to build the two performance counters;
// otherwise both perf outputs are tied to zero and no counter flops exist.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fifo_isfull,
  input  logic        fifo_willfull,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  output logic        fifo_instr1_wen,
  output logic        fifo_instr2_wen,
  output logic [31:0] fifo_instr1_addr,
  output logic [31:0] fifo_instr2_addr,
  output logic [31:0] fifo_instr1_data,
  output logic [31:0] fifo_instr2_data,
  output logic        fifo_instr1_addr_err,
  output logic        fifo_instr2_addr_err,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
);

  fetch_state_t st;
  logic [31:0]  pc;

  logic aligned;
  logic in_req;
  logic accept;
  logic err_wr;
  logic data_wr;
  logic drop;

  always_comb begin
    aligned  = (pc[1:0] == 2'b00);
    in_req   = !reset && (st == REQ);
    // Request is only raised with room for a full doubleword in the FIFO.
    inst_req = in_req && aligned && !fifo_isfull && !fifo_willfull;
    accept   = inst_req && inst_addr_ok;
    // A redirect overrides both the error report and the response write.
    err_wr   = in_req && !aligned && !redirect_valid;
    data_wr  = !reset && (st == WAIT_DATA) && inst_data_ok && !redirect_valid;
    // Responses that never reach the FIFO: stale ones, or ones hit by a redirect.
    drop     = !reset && inst_data_ok &&
               ((st == DISCARD) || ((st == WAIT_DATA) && redirect_valid));
    inst_addr = reset ? 32'd0 : line_addr(pc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      st <= REQ;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      case (st)
        // A request accepted in the redirect cycle still gets a response, which must be dropped.
        REQ:       st <= accept ? DISCARD : REQ;
        WAIT_DATA: st <= inst_data_ok ? REQ : DISCARD;
        DISCARD:   st <= inst_data_ok ? REQ : DISCARD;
        ERR_HOLD:  st <= REQ;
        default:   st <= REQ;
      endcase
    end else begin
      case (st)
        REQ: begin
          if (!aligned) begin
            st <= ERR_HOLD;
          end else if (accept) begin
            st <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (inst_data_ok) begin
            // High-word PC consumed one instruction; low-word PC consumed the whole doubleword.
            pc <= pc + (pc[2] ? PC_STEP_ONE : PC_STEP_PAIR);
            st <= REQ;
          end
        end
        DISCARD: begin
          if (inst_data_ok) begin
            st <= REQ;
          end
        end
        ERR_HOLD: st <= ERR_HOLD;
        default:  st <= REQ;
      endcase
    end
  end

  fetch_pack u_pack (
    .pc              (pc),
    .rdata           (inst_rdata),
    .data_wr         (data_wr),
    .err_wr          (err_wr),
    .instr1_wen      (fifo_instr1_wen),
    .instr2_wen      (fifo_instr2_wen),
    .instr1_addr     (fifo_instr1_addr),
    .instr2_addr     (fifo_instr2_addr),
    .instr1_data     (fifo_instr1_data),
    .instr2_data     (fifo_instr2_data),
    .instr1_addr_err (fifo_instr1_addr_err),
    .instr2_addr_err (fifo_instr2_addr_err)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {31'd0, fifo_instr1_wen} + {31'd0, fifo_instr2_wen};
      if (drop) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  // Masked during reset so the previous run's count never shows while reset is high.
  assign perf_fetch_cnt = reset ? 32'd0 : fetch_cnt_q;
  assign perf_flush_cnt = reset ? 32'd0 : flush_cnt_q;
`else
  logic unused_drop;
  assign unused_drop    = drop;
  assign perf_fetch_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the fetch stage and an I-cache stand-in.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fifo_isfull;
  logic        fifo_willfull;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic        fifo_instr1_wen;
  logic        fifo_instr2_wen;
  logic [31:0] fifo_instr1_addr;
  logic [31:0] fifo_instr2_addr;
  logic [31:0] fifo_instr1_data;
  logic [31:0] fifo_instr2_data;
  logic        fifo_instr1_addr_err;
  logic        fifo_instr2_addr_err;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .fifo_isfull          (fifo_isfull),
    .fifo_willfull        (fifo_willfull),
    .inst_req             (inst_req),
    .inst_addr            (inst_addr),
    .inst_addr_ok         (inst_addr_ok),
    .inst_data_ok         (inst_data_ok),
    .inst_rdata           (inst_rdata),
    .fifo_instr1_wen      (fifo_instr1_wen),
    .fifo_instr2_wen      (fifo_instr2_wen),
    .fifo_instr1_addr     (fifo_instr1_addr),
    .fifo_instr2_addr     (fifo_instr2_addr),
    .fifo_instr1_data     (fifo_instr1_data),
    .fifo_instr2_data     (fifo_instr2_data),
    .fifo_instr1_addr_err (fifo_instr1_addr_err),
    .fifo_instr2_addr_err (fifo_instr2_addr_err),
    .perf_fetch_cnt       (perf_fetch_cnt),
    .perf_flush_cnt       (perf_flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: next PC to fetch, whether a cache access is outstanding,
  // whether its data is already known to be unwanted, and whether fetch is parked.
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_stale;
  logic        m_halt;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;
  int          c_wait;  // cycles the cache stand-in still holds the response back

  // Snapshots of the last sampled outputs for directed checks.
  logic        s_req, s_w1, s_w2, s_e1;
  logic [31:0] s_addr, s_a1, s_a2, s_d1, s_d2, s_pflush;

  task automatic model_reset();
    m_pc    = 32'hBFC0_0000;
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_halt  = 1'b0;
    m_fetch = '0;
    m_flush = '0;
    c_wait  = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input logic rv, input logic [31:0] rp, input logic fl, input logic wf,
                     input logic aok, input logic dok, input logic [63:0] rd);
    logic        can, m_req, errw, goodd;
    logic        e_w1, e_w2, e_e1;
    logic [31:0] e_a1, e_a2, e_d1, e_d2;
    logic [31:0] qa[$];
    logic [31:0] qd[$];

    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = rv;
    redirect_pc    = rp;
    fifo_isfull    = fl;
    fifo_willfull  = wf;
    inst_addr_ok   = aok;
    inst_data_ok   = dok;
    inst_rdata     = rd;
    #1;

    can   = !m_busy && !m_halt;
    m_req = can && (m_pc[1:0] == 2'b00) && !fl && !wf;
    errw  = can && (m_pc[1:0] != 2'b00) && !rv;
    goodd = m_busy && !m_stale && dok && !rv;

    // Useful instructions run from the PC to the end of its doubleword.
    if (goodd) begin
      for (int s = int'(m_pc[2]); s < 2; s++) begin
        qa.push_back({m_pc[31:3], 3'b000} + 32'(4 * s));
        qd.push_back(rd[32*s +: 32]);
      end
    end
    e_w1 = 1'b0; e_w2 = 1'b0; e_e1 = 1'b0;
    e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
    if (errw) begin
      e_w1 = 1'b1; e_a1 = m_pc; e_d1 = '0; e_e1 = 1'b1;
    end else if (qa.size() == 2) begin
      e_w1 = 1'b1; e_a1 = qa[0]; e_d1 = qd[0];
      e_w2 = 1'b1; e_a2 = qa[1]; e_d2 = qd[1];
    end else if (qa.size() == 1) begin
      e_w2 = 1'b1; e_a2 = qa[0]; e_d2 = qd[0];
    end

    check("inst_req", 64'(inst_req), 64'(m_req));
    if (m_req) check("inst_addr", 64'(inst_addr), 64'({m_pc[31:3], 3'b000}));
    check("wen1", 64'(fifo_instr1_wen), 64'(e_w1));
    check("wen2", 64'(fifo_instr2_wen), 64'(e_w2));
    if (e_w1) begin
      check("addr1", 64'(fifo_instr1_addr), 64'(e_a1));
      check("data1", 64'(fifo_instr1_data), 64'(e_d1));
      check("err1", 64'(fifo_instr1_addr_err), 64'(e_e1));
    end
    if (e_w2) begin
      check("addr2", 64'(fifo_instr2_addr), 64'(e_a2));
      check("data2", 64'(fifo_instr2_data), 64'(e_d2));
      check("err2", 64'(fifo_instr2_addr_err), 64'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch));
    check("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`else
    check("perf_fetch", 64'(perf_fetch_cnt), 64'd0);
    check("perf_flush", 64'(perf_flush_cnt), 64'd0);
`endif

    s_req = inst_req; s_addr = inst_addr;
    s_w1 = fifo_instr1_wen; s_a1 = fifo_instr1_addr; s_d1 = fifo_instr1_data;
    s_e1 = fifo_instr1_addr_err;
    s_w2 = fifo_instr2_wen; s_a2 = fifo_instr2_addr; s_d2 = fifo_instr2_data;
    s_pflush = perf_flush_cnt;

    @(posedge clk);
    if (m_busy && !dok && c_wait > 0) c_wait--;
    if (rv) begin
      m_pc   = rp;
      m_halt = 1'b0;
      if (m_busy && dok) begin
        m_busy = 1'b0;
        m_flush++;
      end else if (m_busy) begin
        m_stale = 1'b1;
      end else if (m_req && aok) begin
        m_busy  = 1'b1;
        m_stale = 1'b1;
        c_wait  = $urandom_range(0, 2);
      end
    end else begin
      if (errw) m_halt = 1'b1;
      if (m_busy && dok) begin
        m_busy = 1'b0;
        if (m_stale) m_flush++;
        else m_pc = m_pc + 32'(4 * qa.size());
      end else if (!m_busy && m_req && aok) begin
        m_busy  = 1'b1;
        m_stale = 1'b0;
        c_wait  = $urandom_range(0, 2);
      end
    end
    m_fetch = m_fetch + 32'(e_w1) + 32'(e_w2);
  endtask

  // Reset cycles with random input activity; every output must read zero.
  task automatic rst_cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset          = 1'b1;
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom;
      fifo_isfull    = 1'b0;
      fifo_willfull  = 1'b0;
      inst_addr_ok   = 1'b1;
      inst_data_ok   = 1'($urandom_range(0, 1));
      inst_rdata     = {$urandom, $urandom};
      #1;
      check("rst_req", 64'(inst_req), 64'd0);
      check("rst_addr", 64'(inst_addr), 64'd0);
      check("rst_wen", 64'({fifo_instr1_wen, fifo_instr2_wen}), 64'd0);
      check("rst_perf", 64'({perf_fetch_cnt, perf_flush_cnt}), 64'd0);
      @(posedge clk);
    end
    model_reset();
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    fifo_isfull = 1'b0; fifo_willfull = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    model_reset();
    rst_cyc(3);

    // Aligned pair fetch from the reset vector.
    cyc(0, 0, 0, 0, 1, 0, 64'd0);
    check("d1_addr", 64'(s_addr), 64'h0000_0000_BFC0_0000);
    cyc(0, 0, 0, 0, 0, 1, 64'h11111111_22222222);
    check("d1_pair", 64'({s_w1, s_w2}), 64'd3);
    check("d1_i1", {s_a1, s_d1}, 64'hBFC00000_22222222);
    check("d1_i2", {s_a2, s_d2}, 64'hBFC00004_11111111);
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    check("d1_next", 64'(s_addr), 64'h0000_0000_BFC0_0008);

    // Redirect into the high word: single write into entry 2.
    cyc(1, 32'h8000_0004, 0, 0, 0, 0, 64'd0);
    cyc(0, 0, 0, 0, 1, 0, 64'd0);
    check("d2_addr", 64'(s_addr), 64'h0000_0000_8000_0000);
    cyc(0, 0, 0, 0, 0, 1, 64'hAAAA0000_BBBB0000);
    check("d2_wen", 64'({s_w1, s_w2}), 64'd1);
    check("d2_i2", {s_a2, s_d2}, 64'h80000004_AAAA0000);
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    check("d2_next", 64'(s_addr), 64'h0000_0000_8000_0008);

    // FIFO nearly full holds requests off.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 1, 0, 64'd0);
      check("d3_hold", 64'(s_req), 64'd0);
    end
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    check("d3_release", 64'(s_req), 64'd1);

    // Redirect while waiting for data; late response is dropped.
    cyc(0, 0, 0, 0, 1, 0, 64'd0);
    cyc(1, 32'h8000_1000, 0, 0, 0, 0, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    cyc(0, 0, 0, 0, 0, 1, 64'hDEADBEEF_CAFEF00D);
    check("d4_drop", 64'({s_w1, s_w2}), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    check("d4_next", 64'(s_addr), 64'h0000_0000_8000_1000);
`ifdef FETCH_PERF_CNT_EN
    check("d4_flush", 64'(s_pflush), 64'd1);
`endif

    // Misaligned redirect: one error entry, then parked until the next redirect.
    cyc(1, 32'h8000_0002, 0, 0, 0, 0, 64'd0);
    cyc(0, 0, 0, 0, 1, 0, 64'd0);
    check("d5_err", {28'd0, s_req, s_w1, s_e1, s_w2, s_a1}, {28'd0, 4'b0110, 32'h8000_0002});
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 64'd0);
      check("d5_idle", 64'({s_req, s_w1, s_w2}), 64'd0);
    end
    cyc(1, 32'hBFC0_0380, 0, 0, 0, 0, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    check("d5_restart", {31'd0, s_req, s_addr}, 64'h00000001_BFC00380);

    // Redirect in the same cycle as the response.
    cyc(0, 0, 0, 0, 1, 0, 64'd0);
    cyc(1, 32'h8000_2000, 0, 0, 0, 1, 64'h12345678_9ABCDEF0);
    check("d6_drop", 64'({s_w1, s_w2}), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 64'd0);
    check("d6_next", 64'(s_addr), 64'h0000_0000_8000_2000);

    // Random traffic, with a reset dropped in mid-stream.
    for (int i = 0; i < 4000; i++) begin
      logic        rv, fl, wf;
      logic [31:0] rp;
      int          sel;
      if (i == 2000) rst_cyc(2);
      rv  = ($urandom_range(0, 19) == 0) || (m_halt && $urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 0)      rp = $urandom;
      else if (sel == 1) rp = 32'hFFFF_FFF8 | ($urandom & 32'h4);
      else               rp = $urandom & 32'hFFFF_FFFC;
      fl = ($urandom_range(0, 7) == 0);
      wf = fl || ($urandom_range(0, 5) == 0);
      cyc(rv, rp, fl, wf, 1'($urandom_range(0, 1)), m_busy && (c_wait == 0),
          {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
